// File: rtl/ten_gig_drp_pkg.sv
// Shared types and default sizing for the 10G PCS/PMA DRP arbiter.
package ten_gig_drp_pkg;

  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 1023;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CORE_OWN  = 2'd1,
    USR_ISSUE = 2'd2,
    USR_WAIT  = 2'd3
  } drp_state_e;

endpackage

// File: rtl/drp_timeout_cnt.sv
// Watchdog counter for an outstanding DRP access: counts enabled cycles and
// pulses o_expire in the LIMIT-th consecutive enabled cycle without a clear.
module drp_timeout_cnt
  import ten_gig_drp_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic i_sys_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of waited cycles already completed
  assign o_expire = i_en && !i_clr && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expire) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ten_gig_drp_arbiter.sv
// Arbitrates the GT DRP port between the PCS/PMA core (multi-access tenure) and
// a user requester (single atomic access). Define DRP_TIMEOUT_EN for the DRDY watchdog.
module ten_gig_drp_arbiter
  import ten_gig_drp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_core_req,
  output logic              o_core_gnt,
  input  logic              i_core_den,
  input  logic              i_core_dwe,
  input  logic [ADDR_W-1:0] i_core_daddr,
  input  logic [DATA_W-1:0] i_core_di,
  output logic              o_core_drdy,
  output logic [DATA_W-1:0] o_core_drpdo,
  input  logic              i_usr_req,
  input  logic              i_usr_we,
  input  logic [ADDR_W-1:0] i_usr_addr,
  input  logic [DATA_W-1:0] i_usr_wdata,
  output logic              o_usr_ack,
  output logic [DATA_W-1:0] o_usr_rdata,
  output logic              o_usr_err,
  output logic              o_gt_den,
  output logic              o_gt_dwe,
  output logic [ADDR_W-1:0] o_gt_daddr,
  output logic [DATA_W-1:0] o_gt_di,
  input  logic              i_gt_drdy,
  input  logic [DATA_W-1:0] i_gt_drpdo,
  output logic              o_drp_timeout
);

  drp_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;   // 1 = user owned last
  logic              outstanding_q, outstanding_d;
  logic              core_gnt_q, core_gnt_d;
  logic              usr_we_q, usr_we_d;
  logic [ADDR_W-1:0] usr_addr_q, usr_addr_d;
  logic [DATA_W-1:0] usr_wdata_q, usr_wdata_d;
  logic              usr_den_q, usr_den_d;
  logic              usr_ack_q, usr_ack_d;
  logic [DATA_W-1:0] usr_rdata_q, usr_rdata_d;
  logic              usr_err_q, usr_err_d;
  logic              drp_timeout_q, drp_timeout_d;
  logic              usr_req_eff;
  logic              timeout_expire;

`ifdef DRP_TIMEOUT_EN
  logic cnt_en, cnt_clr;

  assign cnt_en  = (state_q == USR_WAIT) || (core_gnt_q && outstanding_q);
  assign cnt_clr = !cnt_en || i_gt_drdy;

  drp_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .i_sys_clk(i_sys_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (cnt_clr),
    .i_en     (cnt_en),
    .o_expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // The ack cycle is already IDLE; masking the still-high request there keeps
  // one completed access from being replayed and forces the idle gap.
  assign usr_req_eff = i_usr_req && !usr_ack_q;

  // NOTE: every _d gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    outstanding_d = outstanding_q;
    usr_we_d      = usr_we_q;
    usr_addr_d    = usr_addr_q;
    usr_wdata_d   = usr_wdata_q;
    usr_den_d     = 1'b0;
    usr_ack_d     = 1'b0;
    usr_rdata_d   = '0;
    usr_err_d     = 1'b0;
    drp_timeout_d = drp_timeout_q || timeout_expire;

    unique case (state_q)
      IDLE: begin
        if (i_core_req && (!usr_req_eff || last_owner_q)) begin
          state_d      = CORE_OWN;
          last_owner_d = 1'b0;
        end else if (usr_req_eff) begin
          state_d      = USR_ISSUE;
          last_owner_d = 1'b1;
          usr_we_d     = i_usr_we;
          usr_addr_d   = i_usr_addr;
          usr_wdata_d  = i_usr_wdata;
        end
      end
      CORE_OWN: begin
        // A strobe in the same cycle as DRDY starts a new access.
        outstanding_d = (outstanding_q && !i_gt_drdy && !timeout_expire) || i_core_den;
        if (!i_core_req && !outstanding_d) begin
          state_d = IDLE;
        end
      end
      USR_ISSUE: begin
        usr_den_d = 1'b1;
        state_d   = USR_WAIT;
      end
      USR_WAIT: begin
        if (i_gt_drdy) begin
          usr_ack_d   = 1'b1;
          usr_rdata_d = usr_we_q ? '0 : i_gt_drpdo;
          state_d     = IDLE;
        end else if (timeout_expire) begin
          usr_ack_d = 1'b1;
          usr_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    core_gnt_d = (state_d == CORE_OWN);
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      last_owner_q  <= 1'b0;
      outstanding_q <= 1'b0;
      core_gnt_q    <= 1'b0;
      usr_we_q      <= 1'b0;
      usr_addr_q    <= '0;
      usr_wdata_q   <= '0;
      usr_den_q     <= 1'b0;
      usr_ack_q     <= 1'b0;
      usr_rdata_q   <= '0;
      usr_err_q     <= 1'b0;
      drp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      outstanding_q <= outstanding_d;
      core_gnt_q    <= core_gnt_d;
      usr_we_q      <= usr_we_d;
      usr_addr_q    <= usr_addr_d;
      usr_wdata_q   <= usr_wdata_d;
      usr_den_q     <= usr_den_d;
      usr_ack_q     <= usr_ack_d;
      usr_rdata_q   <= usr_rdata_d;
      usr_err_q     <= usr_err_d;
      drp_timeout_q <= drp_timeout_d;
    end
  end

  assign o_core_gnt    = core_gnt_q;
  assign o_core_drdy   = core_gnt_q && (i_gt_drdy || timeout_expire);
  assign o_core_drpdo  = (core_gnt_q && i_gt_drdy) ? i_gt_drpdo : '0;

  assign o_usr_ack     = usr_ack_q;
  assign o_usr_rdata   = usr_rdata_q;
  assign o_usr_err     = usr_err_q;
  assign o_drp_timeout = drp_timeout_q;

  // Address and data are zeroed outside a strobe so the GT only sees live accesses.
  assign o_gt_den   = core_gnt_q ? i_core_den : usr_den_q;
  assign o_gt_dwe   = core_gnt_q ? (i_core_den && i_core_dwe) : (usr_den_q && usr_we_q);
  assign o_gt_daddr = core_gnt_q ? (i_core_den ? i_core_daddr : '0)
                                 : (usr_den_q  ? usr_addr_q   : '0);
  assign o_gt_di    = core_gnt_q ? (i_core_den ? i_core_di    : '0)
                                 : (usr_den_q  ? usr_wdata_q  : '0);

endmodule

// File: doc/ten_gig_drp_arbiter.md
# ten_gig_drp_arbiter

Shares the single GT transceiver DRP port between the 10G PCS/PMA core's DRP master and a user management requester. It replaces the hard-wired request-to-grant loopback around the PCS/PMA core. It grants the DRP either to the core, for a multi-access tenure, or to the user, for one atomic access. Both requesters get fair access, and outstanding accesses are supervised so that a missing DRDY cannot hang the port.

## Interface
Parameters:
- TIMEOUT_CYC, 1023: maximum cycles an issued access waits for GT DRDY (used only with the timeout feature).
- ADDR_W, 16: DRP address width.
- DATA_W, 16: DRP data width.

Ports (one clock; reset asynchronous, active-low):
- i_sys_clk  in  1  DRP clock, same clock as the core's dclk.
- i_rst_n  in  1  asynchronous active-low reset.
- i_core_req  in  1  core drp_req; level, held for the whole tenure.
- o_core_gnt  out  1  core drp_gnt.
- i_core_den, i_core_dwe  in  1 each  core-issued strobes (drp_den_o, drp_dwe_o).
- i_core_daddr  in  ADDR_W  core address.
- i_core_di  in  DATA_W  core write data.
- o_core_drdy  out  1  DRDY returned to the core (drp_drdy_i).
- o_core_drpdo  out  DATA_W  read data returned to the core (drp_drpdo_i).
- i_usr_req  in  1  user access request; level until o_usr_ack.
- i_usr_we  in  1  1 = write, 0 = read.
- i_usr_addr  in  ADDR_W  user address.
- i_usr_wdata  in  DATA_W  user write data.
- o_usr_ack  out  1  one-cycle completion pulse.
- o_usr_rdata  out  DATA_W  read data, valid with o_usr_ack.
- o_usr_err  out  1  completion was a timeout, valid with o_usr_ack.
- o_gt_den, o_gt_dwe  out  1 each  GT DRP strobes.
- o_gt_daddr  out  ADDR_W  GT address.
- o_gt_di  out  DATA_W  GT write data.
- i_gt_drdy  in  1  GT DRDY.
- i_gt_drpdo  in  DATA_W  GT read data.
- o_drp_timeout  out  1  sticky flag: at least one timeout has occurred.

## Operation
- States:
  - IDLE: no owner.
  - CORE_OWN: core holds the grant.
  - USR_ISSUE: user access strobe is issued.
  - USR_WAIT: waiting for DRDY of the user access.
- IDLE, core request only: go to CORE_OWN and assert o_core_gnt.
- IDLE, user request only: go to USR_ISSUE and latch i_usr_we, i_usr_addr and i_usr_wdata.
- IDLE, both requesting: round-robin on a last_owner bit. Reset value 0 means core last, so the user wins the first tie.
- CORE_OWN:
  - Core strobes pass combinationally to the GT; i_gt_drdy and i_gt_drpdo pass to the core.
  - An outstanding flag sets on i_core_den and clears on i_gt_drdy.
  - The grant is released (back to IDLE) only when i_core_req=0 and there is no outstanding access. If the core drops req while an access is outstanding, the grant stays up until DRDY arrives.
- USR_ISSUE:
  - Drive o_gt_den=1 for exactly one cycle, with o_gt_dwe = latched we and the latched address and data.
  - Go to USR_WAIT.
- USR_WAIT:
  - On i_gt_drdy: o_usr_ack=1 and o_usr_rdata = i_gt_drpdo (0 for writes), then go to IDLE.
- GT outputs are 0 whenever the arbiter is not driving an access.
- A core request raised during a user access waits; user accesses are atomic.
- i_gt_drdy arriving in IDLE is ignored.
- Reset mid-access: all state is abandoned and no ack or DRDY is produced. The GT must be reset alongside.

## Timing
- Reset values of all outputs are 0. State resets to IDLE, last_owner to 0 and the timeout counter to 0.
- Grant latency: 1 cycle from i_core_req rising in IDLE to o_core_gnt=1 (registered).
- Release latency: o_core_gnt falls 1 cycle after the release condition holds.
- User latency:
  - o_gt_den is asserted 2 cycles after i_usr_req rises in IDLE (IDLE→USR_ISSUE, then strobe).
  - o_usr_ack follows i_gt_drdy by 1 cycle (registered).
- The requester must drop i_usr_req in the cycle after ack. A request still high after ack is treated as a new access.
- Back-to-back: at least 1 IDLE cycle separates any two tenures.

## Configuration
- DRP_TIMEOUT_EN defined:
  - A counter runs while a user access is in USR_WAIT or a core access is outstanding.
  - The counter reaching TIMEOUT_CYC is the expiry. On expiry in USR_WAIT: o_usr_ack=1, o_usr_err=1, o_usr_rdata=0.
  - On expiry of a core access: synthesize a one-cycle o_core_drdy with o_core_drpdo=0 and clear the outstanding flag.
  - Either expiry sets o_drp_timeout.
- DRP_TIMEOUT_EN undefined: accesses wait indefinitely, and o_usr_err and o_drp_timeout are tied to 0.

## Structure
- Shared package ten_gig_drp_pkg holds:
  - the state enum (IDLE, CORE_OWN, USR_ISSUE, USR_WAIT);
  - the default ADDR_W, DATA_W and TIMEOUT_CYC constants.
- One sub-module, drp_timeout_cnt: a counter with clear/enable inputs and an expiry pulse. It is instantiated only under DRP_TIMEOUT_EN.

## Test plan
- Core tenure: hold i_core_req, issue 3 reads; GT returns DRDY 4 cycles after each with data 0x1234, 0x5678 and 0x9ABC → o_core_gnt=1 one cycle after req, each value passed to o_core_drpdo, gnt drops 1 cycle after req falls.
- User write: addr 0x0044, data 0x4C4B → one-cycle o_gt_den with o_gt_dwe=1 and matching address/data; DRDY after 5 cycles → o_usr_ack, o_usr_err=0.
- Simultaneous requests from reset → user served first, then core granted; on the next tie the user wins again (alternation).
- Early core release: core drops req with a read outstanding → gnt held until DRDY, then released.
- Timeout (DRP_TIMEOUT_EN, TIMEOUT_CYC=16): user read with no DRDY → ack with err=1 and rdata=0 at the expiry cycle, o_drp_timeout=1.
- Reset during USR_WAIT → all outputs 0, no ack, next user request completes normally.
